icache: RTL

Direct-mapped, read-only instruction cache between the fetch stage and backing instruction memory. Fetch presents a PC every cycle. A hit returns the instruction combinationally in the same cycle. A miss asserts `stall`, which fetch uses to freeze the PC and bubble IF/ID, while a 4-word line fill runs over a req/ack handshake to backing memory.

---
 rtl/icache_pkg.sv | 28 ++
 rtl/icache_array.sv | 68 ++++++
 rtl/icache.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
//   Shared constants, the controller state type and a width helper for the
//   direct-mapped instruction cache.
//   Address layout (16-bit byte address):
//     [0]                  must be 0 (16-bit instructions)
//     [2:1]                word offset within a 4-word line
//     [3 +: log2(LINES)]   line index
//     remaining upper bits tag
// -----------------------------------------------------------------------------
package icache_pkg;

   localparam int ADDR_W   = 16;
   localparam int DATA_W   = 16;
   localparam int OFF_W    = 2;          // word offset bits, 4 words per line
   localparam int LINE_LSB = OFF_W + 1;  // lowest index bit, addr[3]

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_e;

   // Tag width left over once offset, byte bit and index are removed.
   function automatic int tag_w(input int lines);
      return ADDR_W - LINE_LSB - $clog2(lines);
   endfunction

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
//   Valid/tag/data storage for the direct-mapped instruction cache.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (clears valid bits)
//     rd_idx_i      line index for the combinational read port
//     rd_valid_o    valid bit of the indexed line
//     rd_tag_o      stored tag of the indexed line
//     rd_line_o     all data words of the indexed line
//     wr_idx_i      line index shared by both write ports
//     word_we_i     write one data word
//     word_sel_i    which word of the line to write
//     word_data_i   data to write
//     tag_we_i      write tag and set valid for wr_idx_i
//     tag_data_i    tag to write
// -----------------------------------------------------------------------------
module icache_array
   import icache_pkg::*;
#(
   parameter  int LINES = 32,
   parameter  int WORDS = 4,
   localparam int IDX_W = $clog2(LINES),
   localparam int TAG_W = tag_w(LINES)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [IDX_W-1:0]             rd_idx_i,
   output logic                         rd_valid_o,
   output logic [TAG_W-1:0]             rd_tag_o,
   output logic [WORDS-1:0][DATA_W-1:0] rd_line_o,
   input  logic [IDX_W-1:0]             wr_idx_i,
   input  logic                         word_we_i,
   input  logic [OFF_W-1:0]             word_sel_i,
   input  logic [DATA_W-1:0]            word_data_i,
   input  logic                         tag_we_i,
   input  logic [TAG_W-1:0]             tag_data_i
);

   logic [LINES-1:0]             valid_q;
   logic [TAG_W-1:0]             tag_q  [LINES];
   logic [WORDS-1:0][DATA_W-1:0] data_q [LINES];

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples its inputs from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (tag_we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // NOTE: tag and data arrays carry no reset; the valid bit qualifies every
   // read, so their power-up contents are never observed.
   always_ff @(posedge clk) begin
      if (tag_we_i) begin
         tag_q[wr_idx_i] <= tag_data_i;
      end
      if (word_we_i) begin
         data_q[wr_idx_i][word_sel_i] <= word_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
//   Direct-mapped, read-only instruction cache. Hits return the word in the
//   same cycle; a miss stalls fetch while a 4-word line is filled in order
//   (word 0..3) over a req/ack handshake. A fill, once started, always
//   completes unless reset is asserted.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     addr, rd     fetch byte address and request valid
//     instr, done  instruction word and its valid strobe (instr is 0 otherwise)
//     stall        miss in progress, fetch holds addr
//     hit          done served from the array without a fill
//     err          misaligned fetch, or mem_ack while no fill is running
//     mem_req      word read request to backing memory
//     mem_addr     byte address of the requested word
//     mem_ack      one-cycle acknowledge, mem_rdata valid
//     mem_rdata    returned word
// -----------------------------------------------------------------------------
module icache
   import icache_pkg::*;
#(
   parameter int LINES = 32,
   parameter int WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd,
   output logic [DATA_W-1:0] instr,
   output logic              done,
   output logic              stall,
   output logic              hit,
   output logic              err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = tag_w(LINES);
   localparam int LINE_W = IDX_W + TAG_W;   // {tag, index} of a line

   state_e              state_q, state_d;
   logic [OFF_W-1:0]    wcnt_q, wcnt_d;
   logic [LINE_W-1:0]   fill_addr_q, fill_addr_d;

   logic [OFF_W-1:0]    pc_off;
   logic [IDX_W-1:0]    pc_idx;
   logic [TAG_W-1:0]    pc_tag;
   logic [IDX_W-1:0]    fill_idx;
   logic [TAG_W-1:0]    fill_tag;

   logic                line_valid;
   logic [TAG_W-1:0]    line_tag;
   logic [WORDS-1:0][DATA_W-1:0] line_data;
   logic                tag_match;
   logic                word_we;
   logic                tag_we;

   assign pc_off    = addr[LINE_LSB-1:1];
   assign pc_idx    = addr[LINE_LSB +: IDX_W];
   assign pc_tag    = addr[ADDR_W-1 -: TAG_W];
   assign fill_idx  = fill_addr_q[IDX_W-1:0];
   assign fill_tag  = fill_addr_q[LINE_W-1 -: TAG_W];
   assign tag_match = line_valid && (line_tag == pc_tag);

   icache_array #(
      .LINES (LINES),
      .WORDS (WORDS)
   ) u_array (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (pc_idx),
      .rd_valid_o  (line_valid),
      .rd_tag_o    (line_tag),
      .rd_line_o   (line_data),
      .wr_idx_i    (fill_idx),
      .word_we_i   (word_we),
      .word_sel_i  (wcnt_q),
      .word_data_i (mem_rdata),
      .tag_we_i    (tag_we),
      .tag_data_i  (fill_tag)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      fill_addr_d = fill_addr_q;
      instr       = '0;
      done        = 1'b0;
      hit         = 1'b0;
      stall       = 1'b0;
      mem_req     = 1'b0;
      mem_addr    = '0;
      word_we     = 1'b0;
      tag_we      = 1'b0;
      err         = rd & addr[0];

      case (state_q)
         ST_IDLE: begin
            // An ack with no request outstanding is a protocol error; the
            // data is dropped.
            if (mem_ack) begin
               err = 1'b1;
            end
            if (rd && !addr[0]) begin
               if (tag_match) begin
                  done  = 1'b1;
                  hit   = 1'b1;
                  instr = line_data[pc_off];
               end else begin
                  stall       = 1'b1;
                  fill_addr_d = addr[ADDR_W-1:LINE_LSB];
                  wcnt_d      = '0;
                  state_d     = ST_FILL;
               end
            end
         end

         ST_FILL: begin
            // Fill address comes from the latched miss, not the live PC, so a
            // redirect during the fill still installs the original line.
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {fill_addr_q, wcnt_q, 1'b0};
            // Writes are suppressed while reset aborts the fill.
            if (mem_ack && !rst) begin
               word_we = 1'b1;
               wcnt_d  = wcnt_q + OFF_W'(1);
               if (wcnt_q == OFF_W'(WORDS - 1)) begin
                  tag_we  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= '0;
         fill_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         fill_addr_q <= fill_addr_d;
      end
   end

endmodule
